seq_cbadder: RTL and testbench
==============================

Name: seq_cbadder

Overview:
Parametrised multi-cycle carry-bypass adder/subtractor. It processes one BLOCK-bit slice per clock, LSB slice first. A registered carry passes between slices, and each slice uses carry-bypass (skip) logic. Operands come in and results go out through valid/ready handshakes, so the block sits between operand producers and result consumers in the datapath. It generalises the fixed 4-bit combinational carry-bypass adder to any width, adds a subtract mode, a signed-overflow flag and a bypass statistic.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of BLOCK (elaboration error otherwise).
BLOCK, 4, bits per carry-bypass slice, i.e. bits resolved per cycle; 1 <= BLOCK <= WIDTH.
NBLK, WIDTH/BLOCK, derived (localparam): number of slices, equal to the number of RUN cycles.
CW, $clog2(NBLK+1), derived (localparam): width of skip_count.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operands valid.
in_ready  out  1  block can accept operands (high only in IDLE).
a  in  WIDTH  operand A (unsigned or two's complement).
b  in  WIDTH  operand B.
cin  in  1  carry-in; acts as borrow-in when sub=1.
sub  in  1  0: a+b+cin; 1: a+~b+(~cin), i.e. a-b-cin.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
sum  out  WIDTH  result.
cout  out  1  carry out of MSB; for subtract, 1 = no borrow.
ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.
skip_count  out  CW  number of slices whose propagate was all-ones (bypass path taken).

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; ovf=0; skip_count=0; internal operand, carry and slice-index registers cleared.
- FSM states are IDLE, RUN and DONE.
- IDLE: in_ready=1. Operands are accepted on the edge where in_valid&in_ready is high. At that edge:
  - latch a;
  - latch b_eff = sub ? ~b : b;
  - set carry = cin ^ sub;
  - set idx=0 and skip_count=0;
  - go to RUN.
- RUN: in_ready=0. Each cycle processes slice idx, covering bits [idx*BLOCK +: BLOCK].
  - Compute P = &(a^b_eff) and G-ripple within the slice.
  - Slice carry-out = P ? carry : rippled carry-out. The result must equal a plain ripple add.
  - Write the slice's sum bits.
  - If P=1, skip_count increments.
  - For the last slice, capture the MSB carry-in for ovf.
  - After slice NBLK-1, go to DONE.
  - RUN lasts exactly NBLK cycles.
- DONE: out_valid=1. sum, cout, ovf and skip_count are stable and held while out_ready=0. On the edge where out_valid&out_ready is high, go to IDLE and drop out_valid. in_valid is ignored in RUN and DONE, with no buffering.
- Latency: accept edge to out_valid high is NBLK+1 edges. The minimum issue interval is NBLK+2 cycles when out_ready is held high.
- Outputs persist into IDLE until the next accept. Partial sum bits are not externally guaranteed during RUN.
- Reset mid-RUN or mid-DONE aborts immediately to the reset values. No result is emitted.
- Corner values:
  - BLOCK=WIDTH gives NBLK=1 and a single RUN cycle.
  - BLOCK=1 degenerates to a bit-serial adder.
  - cout and ovf follow the definitions above for all 2^(2W+2) input combinations.

Test Plan:
1. WIDTH=16, BLOCK=4, a=0x00FF, b=0xFF00, cin=1, sub=0 -> sum=0x0000, cout=1, ovf=0, skip_count=4; out_valid rises exactly 5 edges after accept.
2. a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0, skip_count=3.
3. a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1, skip_count=2.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid, toggling in_valid with new operands -> out_valid stays 1, outputs unchanged, in_ready=0, no new operand captured. out_ready=1 -> IDLE next edge, in_ready=1.
5. Assert rst_n=0 asynchronously after 2 RUN cycles -> all outputs go to reset values without waiting for a clock edge. After release, a fresh operation completes correctly.
6. Exhaustive: configs (WIDTH=4, BLOCK=4), (4,2), (4,1); all a, b, cin, sub -> sum/cout/ovf match a reference model; skip_count equals the count of all-ones slices of a^b_eff; latency equals NBLK+1.

Source files
------------

// File: rtl/seq_cbadder.sv
// seq_cbadder: multi-cycle carry-bypass adder/subtractor.
// One BLOCK-bit slice is resolved per clock, LSB slice first, with a
// registered carry between slices and carry-bypass (skip) logic per slice.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   a, b, cin, sub        operands; sub=1 computes a-b-cin (cin is borrow-in)
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   sum, cout, ovf        result, carry out of MSB (1 = no borrow), signed overflow
//   skip_count            number of slices whose propagate was all-ones
module seq_cbadder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4,
  localparam int unsigned NBLK = WIDTH / BLOCK,
  localparam int unsigned CW   = $clog2(NBLK + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [CW-1:0]    skip_count
);

  if (BLOCK < 1 || BLOCK > WIDTH) begin : g_bad_block
    $error("seq_cbadder: BLOCK must satisfy 1 <= BLOCK <= WIDTH");
  end else if (WIDTH % BLOCK != 0) begin : g_bad_width
    $error("seq_cbadder: WIDTH must be a multiple of BLOCK");
  end

  localparam int unsigned IW = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    skip_q, skip_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [BLOCK-1:0] sl_p;
  logic [BLOCK-1:0] sl_g;
  logic [BLOCK-1:0] sl_s;
  logic             sl_rip;
  logic             sl_prop;
  logic             sl_cout;
  logic             sl_cmsb;
  logic             last;

  // Current slice always sits in the low BLOCK bits of the operand
  // registers: operands shift right one slice per RUN cycle instead of
  // being indexed by idx.
  always_comb begin : slice
    logic c;
    sl_p = a_q[BLOCK-1:0] ^ b_q[BLOCK-1:0];
    sl_g = a_q[BLOCK-1:0] & b_q[BLOCK-1:0];
    sl_s = '0;
    c    = carry_q;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      sl_s[i] = sl_p[i] ^ c;
      c       = sl_g[i] | (sl_p[i] & c);
    end
    sl_rip  = c;
    sl_prop = &sl_p;
    // Bypass: an all-propagate slice forwards its carry-in unchanged.
    sl_cout = sl_prop ? carry_q : sl_rip;
    // Carry into the slice MSB, recovered from sum = p ^ carry.
    sl_cmsb = sl_s[BLOCK-1] ^ sl_p[BLOCK-1];
  end

  assign last = (idx_q == IW'(NBLK - 1));

  always_comb begin : fsm_next
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    skip_d  = skip_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          idx_d   = '0;
          skip_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> BLOCK;
        b_d     = b_q >> BLOCK;
        // Slice sums enter at the top and shift down; after NBLK cycles
        // slice 0 lands in the LSBs.
        sum_d   = (sum_q >> BLOCK) | (WIDTH'(sl_s) << (WIDTH - BLOCK));
        carry_d = sl_cout;
        idx_d   = idx_q + IW'(1);
        if (sl_prop) begin
          skip_d = skip_q + CW'(1);
        end
        if (last) begin
          cout_d  = sl_cout;
          ovf_d   = sl_cmsb ^ sl_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      skip_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      skip_q  <= skip_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign sum        = sum_q;
  assign cout       = cout_q;
  assign ovf        = ovf_q;
  assign skip_count = skip_q;

endmodule

// File: tb/tb_seq_cbadder.sv
module tb_seq_cbadder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit / 4-bit-slice instance
  logic        iv16, ir16, cin16, sub16, ov16, or16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic [2:0]  sk16;

  seq_cbadder #(.WIDTH(16), .BLOCK(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16),
    .ovf(of16), .skip_count(sk16)
  );

  // 4-bit instances sharing stimulus
  logic       siv, sor, scin, ssub;
  logic [3:0] sa, sb;
  logic       ir44, ov44, co44, of44;
  logic       ir42, ov42, co42, of42;
  logic       ir41, ov41, co41, of41;
  logic [3:0] s44, s42, s41;
  logic [0:0] sk44;
  logic [1:0] sk42;
  logic [2:0] sk41;

  seq_cbadder #(.WIDTH(4), .BLOCK(4)) u44 (
    .clk(clk), .rst_n(rst_n), .in_valid(siv), .in_ready(ir44),
    .a(sa), .b(sb), .cin(scin), .sub(ssub),
    .out_valid(ov44), .out_ready(sor), .sum(s44), .cout(co44),
    .ovf(of44), .skip_count(sk44)
  );
  seq_cbadder #(.WIDTH(4), .BLOCK(2)) u42 (
    .clk(clk), .rst_n(rst_n), .in_valid(siv), .in_ready(ir42),
    .a(sa), .b(sb), .cin(scin), .sub(ssub),
    .out_valid(ov42), .out_ready(sor), .sum(s42), .cout(co42),
    .ovf(of42), .skip_count(sk42)
  );
  seq_cbadder #(.WIDTH(4), .BLOCK(1)) u41 (
    .clk(clk), .rst_n(rst_n), .in_valid(siv), .in_ready(ir41),
    .a(sa), .b(sb), .cin(scin), .sub(ssub),
    .out_valid(ov41), .out_ready(sor), .sum(s41), .cout(co41),
    .ovf(of41), .skip_count(sk41)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer addition on the effective operands.
  function automatic void model(input int w, input int blk, input longint a, input longint b,
                                input bit cin, input bit sub, output longint s,
                                output bit co, output bit ov, output int sk);
    longint mask, be, tot, sm, x;
    bit sa_, sb_, ss_;
    mask = (longint'(1) << w) - 1;
    be   = sub ? (~b & mask) : (b & mask);
    tot  = (a & mask) + be + longint'(cin ^ sub);
    s    = tot & mask;
    co   = ((tot >> w) & 1) != 0;
    sa_  = ((a >> (w - 1)) & 1) != 0;
    sb_  = ((be >> (w - 1)) & 1) != 0;
    ss_  = ((s >> (w - 1)) & 1) != 0;
    ov   = (sa_ == sb_) && (ss_ != sa_);
    sm   = (longint'(1) << blk) - 1;
    x    = (a & mask) ^ be;
    sk   = 0;
    for (int k = 0; k < w / blk; k++)
      if (((x >> (k * blk)) & sm) == sm) sk++;
  endfunction

  task automatic start16(input logic [15:0] a, input logic [15:0] b, input bit c, input bit s);
    @(negedge clk);
    a16 = a; b16 = b; cin16 = c; sub16 = s; iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
  endtask

  // lat counts edges from accept; -1 if out_valid never arrived
  task automatic wait16(output int lat);
    lat = 1;
    while (ov16 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (ov16 !== 1'b1) lat = -1;
  endtask

  task automatic release16();
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a, b;
    bit          cin, sub;
    logic [15:0] s;
    bit          co, ov;
    int          sk;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, blk, esk;
    longint es;
    bit eco, eov;
    logic [15:0] ra, rb;
    bit rc, rs;
    logic [9:0] vv;
    int slat[3];
    logic [3:0] asum[3];
    logic aco[3], aof[3], aov[3];
    logic [2:0] ask[3];

    tbl[0] = '{16'h00FF, 16'hFF00, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4};
    tbl[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 3};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 2};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0};
    tbl[5] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4};

    iv16 = 0; or16 = 0; a16 = '0; b16 = '0; cin16 = 0; sub16 = 0;
    siv = 0; sor = 0; sa = '0; sb = '0; scin = 0; ssub = 0;

    #3;
    chk("rst_in_ready", ir16, 1);
    chk("rst_out_valid", ov16, 0);
    chk("rst_sum", s16, 0);
    chk("rst_cout", co16, 0);
    chk("rst_ovf", of16, 0);
    chk("rst_skip", sk16, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 6; i++) begin
      start16(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      wait16(lat);
      chk($sformatf("tbl%0d_lat", i), lat, 5);
      chk($sformatf("tbl%0d_sum", i), s16, tbl[i].s);
      chk($sformatf("tbl%0d_cout", i), co16, tbl[i].co);
      chk($sformatf("tbl%0d_ovf", i), of16, tbl[i].ov);
      chk($sformatf("tbl%0d_skip", i), sk16, tbl[i].sk);
      release16();
      chk($sformatf("tbl%0d_idle", i), ir16, 1);
    end

    // randomized against model, with random backpressure
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) rb = ra ^ 16'hFFFF;
      model(16, 4, longint'(ra), longint'(rb), rc, rs, es, eco, eov, esk);
      start16(ra, rb, rc, rs);
      wait16(lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk($sformatf("rnd%0d_lat", i), lat, 5);
      chk($sformatf("rnd%0d_sum", i), s16, es);
      chk($sformatf("rnd%0d_cout", i), co16, eco);
      chk($sformatf("rnd%0d_ovf", i), of16, eov);
      chk($sformatf("rnd%0d_skip", i), sk16, esk);
      release16();
    end

    // backpressure: result held, new operands ignored
    start16(16'h1234, 16'h0101, 1'b0, 1'b0);
    wait16(lat);
    chk("bp_lat", lat, 5);
    for (int k = 0; k < 5; k++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); iv16 = ~iv16;
      @(negedge clk);
      chk($sformatf("bp%0d_valid", k), ov16, 1);
      chk($sformatf("bp%0d_ready", k), ir16, 0);
      chk($sformatf("bp%0d_sum", k), s16, 16'h1335);
      chk($sformatf("bp%0d_skip", k), sk16, 0);
    end
    iv16 = 1'b0;
    release16();
    chk("bp_idle_ready", ir16, 1);
    chk("bp_idle_valid", ov16, 0);
    chk("bp_persist_sum", s16, 16'h1335);

    // asynchronous reset in the middle of RUN
    start16(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", ov16, 0);
    chk("arst_ready", ir16, 1);
    chk("arst_sum", s16, 0);
    chk("arst_cout", co16, 0);
    chk("arst_ovf", of16, 0);
    chk("arst_skip", sk16, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait16(lat);
    chk("post_rst_lat", lat, 5);
    chk("post_rst_sum", s16, 16'h0000);
    chk("post_rst_cout", co16, 1);
    chk("post_rst_skip", sk16, 3);
    release16();

    // exhaustive 4-bit configs
    for (int v = 0; v < 1024; v++) begin
      vv = v[9:0];
      @(negedge clk);
      sa = vv[3:0]; sb = vv[7:4]; scin = vv[8]; ssub = vv[9]; siv = 1'b1;
      @(negedge clk);
      siv = 1'b0;
      slat[0] = 0; slat[1] = 0; slat[2] = 0;
      n = 1;
      while (n <= 8) begin
        if (slat[0] == 0 && ov44 === 1'b1) slat[0] = n;
        if (slat[1] == 0 && ov42 === 1'b1) slat[1] = n;
        if (slat[2] == 0 && ov41 === 1'b1) slat[2] = n;
        if (slat[0] != 0 && slat[1] != 0 && slat[2] != 0) break;
        @(negedge clk);
        n++;
      end
      asum[0] = s44; aco[0] = co44; aof[0] = of44; ask[0] = {2'b00, sk44}; aov[0] = ov44;
      asum[1] = s42; aco[1] = co42; aof[1] = of42; ask[1] = {1'b0, sk42};  aov[1] = ov42;
      asum[2] = s41; aco[2] = co41; aof[2] = of41; ask[2] = sk41;          aov[2] = ov41;
      for (int c = 0; c < 3; c++) begin
        blk = (c == 0) ? 4 : ((c == 1) ? 2 : 1);
        model(4, blk, longint'(vv[3:0]), longint'(vv[7:4]), vv[8], vv[9], es, eco, eov, esk);
        chk($sformatf("x%0d_v%0d_lat", blk, v), slat[c], 4 / blk + 1);
        chk($sformatf("x%0d_v%0d_valid", blk, v), aov[c], 1);
        chk($sformatf("x%0d_v%0d_sum", blk, v), asum[c], es);
        chk($sformatf("x%0d_v%0d_cout", blk, v), aco[c], eco);
        chk($sformatf("x%0d_v%0d_ovf", blk, v), aof[c], eov);
        chk($sformatf("x%0d_v%0d_skip", blk, v), ask[c], esk);
      end
      sor = 1'b1;
      @(negedge clk);
      sor = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
